// File: rtl/icache_ctrl.sv
// Direct-mapped 16-frame instruction cache controller with a single outstanding
// miss; hits are combinational and misses block until memory returns the word.
module icache_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    input  logic             flush,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    typedef struct packed {
        logic [25:0] tag;
        logic [3:0]  idx;
        logic [1:0]  bytoff;
    } icachef_t;

    state_t      state_q;
    state_t      next_state;
    icachef_t    req;
    logic        unused_bytoff;

    logic [15:0] valid_q;
    logic [25:0] tag_q  [16];
    logic [31:0] data_q [16];

    logic [25:0] fill_tag_q;
    logic [3:0]  fill_idx_q;

    logic        tag_match;
    logic        miss;
    logic        fill_done;

    assign req           = imemaddr;
    assign unused_bytoff = ^req.bytoff;
    assign tag_match     = valid_q[req.idx] && (tag_q[req.idx] == req.tag);

    // Reset forces every output low; flush suppresses a hit so a stale frame is never returned.
    always_comb begin
        next_state = state_q;
        ihit       = 1'b0;
        imemload   = 32'h0;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        miss       = 1'b0;
        fill_done  = 1'b0;
        if (!RST) begin
            imemload = data_q[req.idx];
            case (state_q)
                IDLE: begin
                    ihit = imemREN && tag_match && !flush;
                    if (imemREN && !ihit) begin
                        miss       = 1'b1;
                        next_state = FETCH;
                    end
                end
                FETCH: begin
                    iREN  = 1'b1;
                    iaddr = {fill_tag_q, fill_idx_q, 2'b00};
                    if (!iwait) begin
                        fill_done  = 1'b1;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && miss) begin
            fill_tag_q <= req.tag;
            fill_idx_q <= req.idx;
        end
    end

    // A fill coincident with flush still writes tag/data but the frame stays invalid.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            valid_q <= '0;
        end else if (fill_done) begin
            valid_q[fill_idx_q] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[fill_idx_q]  <= fill_tag_q;
            data_q[fill_idx_q] <= iload;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (ihit) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (miss) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule
